// File: rtl/add8_err_meter.sv
// Error-characterization engine for 8-bit approximate adders: sweeps all 65536 operand pairs
// into an attached adder and accumulates MAE/MSE/WCE/EP/HD figures of merit.
module add8_err_meter #(
  parameter int unsigned DUT_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  dut_a,
  output logic [7:0]  dut_b,
  input  logic [8:0]  dut_o,
  output logic        busy,
  output logic        done,
  output logic [24:0] sum_abs,
  output logic [33:0] sum_sq,
  output logic [8:0]  wce,
  output logic [16:0] err_cnt,
  output logic [19:0] hd_sum
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // DRAIN ends when the last aligned sample has reached the accumulators, so that
  // done coincides with the first cycle the results are final.
  localparam logic [1:0] DrainLast = DUT_LAT[1:0];

  logic [1:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  drain_q, drain_d;
  logic        clr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    clr     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = 16'd0;
          clr     = 1'b1;
        end
      end
      StRun: begin
        if (idx_q == 16'hFFFF) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        if (start) begin
          state_d = StRun;
          idx_d   = 16'd0;
          clr     = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 16'd0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  assign dut_a = idx_q[15:8];
  assign dut_b = idx_q[7:0];
  assign busy  = (state_q == StRun) || (state_q == StDrain);
  assign done  = (state_q == StDone);

  // Exact reference and its valid bit, delayed to line up with dut_o.
  logic [8:0] e0, e_al;
  logic       v0, v_al;

  assign e0 = {1'b0, dut_a} + {1'b0, dut_b};
  assign v0 = (state_q == StRun);

  if (DUT_LAT == 0) begin : g_nolat
    assign e_al = e0;
    assign v_al = v0;
  end else begin : g_lat
    logic [8:0]         e_sr [DUT_LAT];
    logic [DUT_LAT-1:0] v_sr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_sr <= '0;
        for (int i = 0; i < int'(DUT_LAT); i++) begin
          e_sr[i] <= 9'd0;
        end
      end else begin
        v_sr[0] <= v0;
        e_sr[0] <= e0;
        for (int i = 1; i < int'(DUT_LAT); i++) begin
          v_sr[i] <= v_sr[i-1];
          e_sr[i] <= e_sr[i-1];
        end
      end
    end

    assign e_al = e_sr[DUT_LAT-1];
    assign v_al = v_sr[DUT_LAT-1];
  end

  // Stage 1: per-vector error terms.
  logic [8:0]  d_c;
  logic [17:0] sq_c;
  logic [8:0]  x_c;
  logic [3:0]  p_c;

  always_comb begin
    d_c  = (e_al >= dut_o) ? (e_al - dut_o) : (dut_o - e_al);
    sq_c = {9'd0, d_c} * {9'd0, d_c};
    x_c  = e_al ^ dut_o;
    p_c  = 4'd0;
    for (int i = 0; i < 9; i++) begin
      p_c = p_c + {3'd0, x_c[i]};
    end
  end

  logic        s1_v_q;
  logic [8:0]  s1_d_q;
  logic [17:0] s1_sq_q;
  logic        s1_nz_q;
  logic [3:0]  s1_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_d_q  <= 9'd0;
      s1_sq_q <= 18'd0;
      s1_nz_q <= 1'b0;
      s1_p_q  <= 4'd0;
    end else begin
      s1_v_q  <= v_al;
      s1_d_q  <= d_c;
      s1_sq_q <= sq_c;
      s1_nz_q <= (d_c != 9'd0);
      s1_p_q  <= p_c;
    end
  end

  // Stage 2: accumulators; widths cover a full 65536-vector sweep without overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_abs <= 25'd0;
      sum_sq  <= 34'd0;
      wce     <= 9'd0;
      err_cnt <= 17'd0;
      hd_sum  <= 20'd0;
    end else if (clr) begin
      sum_abs <= 25'd0;
      sum_sq  <= 34'd0;
      wce     <= 9'd0;
      err_cnt <= 17'd0;
      hd_sum  <= 20'd0;
    end else if (s1_v_q) begin
      sum_abs <= sum_abs + {16'd0, s1_d_q};
      sum_sq  <= sum_sq + {16'd0, s1_sq_q};
      err_cnt <= err_cnt + {16'd0, s1_nz_q};
      hd_sum  <= hd_sum + {16'd0, s1_p_q};
      if (s1_d_q > wce) begin
        wce <= s1_d_q;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_meter.sv
// Bench for add8_err_meter: six instances sweep concurrently with different adder models,
// and a scoreboard checks each done pulse's cycle and results against a reference model.
module tb_add8_err_meter;

  localparam int N = 6;

  typedef struct {
    logic [24:0] sa;
    logic [33:0] sq;
    logic [8:0]  wce;
    logic [16:0] ec;
    logic [19:0] hd;
  } res_t;

  typedef struct {
    int inst;
    int mode;
    int done_off;
  } vec_t;

  typedef struct {
    int   inst;
    int   done_cyc;
    res_t exp;
  } sb_t;

  logic          clk;
  logic [N-1:0]  rst_v;
  logic [N-1:0]  start_v;
  logic [N-1:0]  busy_v;
  logic [N-1:0]  done_v;
  logic [7:0]    a_v   [N];
  logic [7:0]    b_v   [N];
  logic [8:0]    o_v   [N];
  logic [24:0]   sa_v  [N];
  logic [33:0]   sq_v  [N];
  logic [8:0]    wce_v [N];
  logic [16:0]   ec_v  [N];
  logic [19:0]   hd_v  [N];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  sb_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Instance map: 0 exact, 1 stuck-at-zero, 2 LSB-masked, 3 exact with two register stages,
  // 4 exact (aborted and restarted), 5 stuck-at-zero with start held high.
  for (genvar g = 0; g < N; g++) begin : gi
    localparam int Lat  = (g == 3) ? 2 : 0;
    localparam int Mode = (g == 1 || g == 5) ? 1 : (g == 2) ? 2 : 0;
    logic [8:0] sum_c, r1, r2;

    assign sum_c = {1'b0, a_v[g]} + {1'b0, b_v[g]};
    always @(posedge clk) begin
      r1 <= sum_c;
      r2 <= r1;
    end

    if (Lat == 2) begin : m_reg
      assign o_v[g] = r2;
    end else if (Mode == 1) begin : m_zero
      assign o_v[g] = 9'd0;
    end else if (Mode == 2) begin : m_mask
      assign o_v[g] = sum_c & 9'h1FE;
    end else begin : m_exact
      assign o_v[g] = sum_c;
    end

    add8_err_meter #(.DUT_LAT(Lat)) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .start   (start_v[g]),
      .dut_a   (a_v[g]),
      .dut_b   (b_v[g]),
      .dut_o   (o_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .sum_abs (sa_v[g]),
      .sum_sq  (sq_v[g]),
      .wce     (wce_v[g]),
      .err_cnt (ec_v[g]),
      .hd_sum  (hd_v[g])
    );
  end

  function automatic res_t calc(int mode, int nvec);
    res_t   r;
    longint sa = 0, sq = 0, ec = 0, hd = 0, wc = 0;
    for (int i = 0; i < nvec; i++) begin
      int e, o, d;
      e = (i >> 8) + (i & 255);
      o = (mode == 1) ? 0 : (mode == 2) ? (e & 'h1FE) : e;
      d = (e > o) ? (e - o) : (o - e);
      sa += d;
      sq += longint'(d) * longint'(d);
      if (d != 0) ec++;
      if (d > wc) wc = d;
      hd += $countones(e ^ o);
    end
    r.sa  = 25'(sa);
    r.sq  = 34'(sq);
    r.wce = 9'(wc);
    r.ec  = 17'(ec);
    r.hd  = 20'(hd);
    return r;
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard consumer: every done pulse must match a pending entry for that instance.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (done_v[g]) begin
        int found;
        found = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (found < 0 && sb[j].inst == g) found = j;
        end
        if (found < 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: inst %0d at cycle %0d", g, cyc);
        end else begin
          chk($sformatf("done_cycle[%0d]", g), 64'(cyc), 64'(sb[found].done_cyc));
          chk($sformatf("busy_at_done[%0d]", g), 64'(busy_v[g]), 64'd0);
          chk($sformatf("sum_abs[%0d]", g), 64'(sa_v[g]), 64'(sb[found].exp.sa));
          chk($sformatf("sum_sq[%0d]", g), 64'(sq_v[g]), 64'(sb[found].exp.sq));
          chk($sformatf("wce[%0d]", g), 64'(wce_v[g]), 64'(sb[found].exp.wce));
          chk($sformatf("err_cnt[%0d]", g), 64'(ec_v[g]), 64'(sb[found].exp.ec));
          chk($sformatf("hd_sum[%0d]", g), 64'(hd_v[g]), 64'(sb[found].exp.hd));
          sb.delete(found);
        end
      end
    end
  end

  initial begin
    vec_t tv [5];
    res_t m_res [3];
    res_t part;
    int   k, k4;

    rst_v   = '1;
    start_v = '0;
    tv[0] = '{inst: 0, mode: 0, done_off: 65537};
    tv[1] = '{inst: 1, mode: 1, done_off: 65537};
    tv[2] = '{inst: 2, mode: 2, done_off: 65537};
    tv[3] = '{inst: 3, mode: 0, done_off: 65539};
    tv[4] = '{inst: 5, mode: 1, done_off: 65537};
    for (int m = 0; m < 3; m++) m_res[m] = calc(m, 65536);

    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("reset_ctrl[%0d]", g), 64'({busy_v[g], done_v[g], a_v[g], b_v[g]}), 64'd0);
      chk($sformatf("reset_acc[%0d]", g),
          64'({sa_v[g], wce_v[g], ec_v[g]}) | 64'(sq_v[g]) | 64'(hd_v[g]), 64'd0);
    end
    rst_v = '0;
    @(negedge clk);

    start_v = '1;
    k = cyc + 1;
    for (int t = 0; t < 5; t++) begin
      sb.push_back('{inst: tv[t].inst, done_cyc: k + tv[t].done_off, exp: m_res[tv[t].mode]});
    end
    @(negedge clk);
    start_v = 6'b100000;
    chk("busy_after_start", 64'(busy_v), 64'h3F);
    chk("vector0", 64'({a_v[0], b_v[0]}), 64'd0);

    wait_until(k + 99);
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;

    wait_until(k + 300);
    chk("vector300_a", 64'(a_v[0]), 64'd1);
    chk("vector300_b", 64'(b_v[0]), 64'd44);
    chk("vector300_lat2", 64'({a_v[3], b_v[3]}), 64'd300);

    wait_until(k + 998);
    chk("busy_before_abort", 64'(busy_v[4]), 64'd1);
    rst_v[4] = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", 64'({busy_v[4], done_v[4], a_v[4], b_v[4]}), 64'd0);
    chk("abort_acc", 64'({sa_v[4], wce_v[4], ec_v[4]}) | 64'(sq_v[4]) | 64'(hd_v[4]), 64'd0);
    rst_v[4] = 1'b0;
    @(negedge clk);
    start_v[4] = 1'b1;
    k4 = cyc + 1;
    sb.push_back('{inst: 4, done_cyc: k4 + 65537, exp: m_res[0]});
    @(negedge clk);
    start_v[4] = 1'b0;

    wait_until(k + 65538);
    chk("b2b_busy", 64'(busy_v[5]), 64'd1);
    chk("b2b_done_low", 64'(done_v[5]), 64'd0);
    chk("b2b_cleared", 64'({sa_v[5], wce_v[5], ec_v[5]}) | 64'(sq_v[5]) | 64'(hd_v[5]), 64'd0);
    chk("idle_after_done", 64'({busy_v[1], done_v[1]}), 64'd0);

    wait_until(k + 65548);
    part = calc(1, 9);
    chk("b2b_partial_abs", 64'(sa_v[5]), 64'(part.sa));
    chk("b2b_partial_cnt", 64'(ec_v[5]), 64'(part.ec));
    chk("b2b_partial_hd", 64'(hd_v[5]), 64'(part.hd));

    while (sb.size() != 0 && cyc < k4 + 65600) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
